// File: rtl/ahb2apb_periph_bridge_if.sv
// AHB-lite responder side plus APB3 requester side of the peripheral bridge.
// The slave modport is the bridge; the master modport is the AHB initiator plus APB peripherals.
interface ahb2apb_periph_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;
    logic [ADDR_W-1:0] paddr;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb2apb_periph_bridge.sv
// AHB-lite to APB3 bridge: one outstanding transfer, all outputs registered.
// Define AHB2APB_TIMEOUT_EN to force an error when ACCESS stalls for TIMEOUT cycles.
module ahb2apb_periph_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NSLV        = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT     = 255
) (
    input  logic                    hclk,
    input  logic                    hreset,
    ahb2apb_periph_bridge_if.slave  bus
);
    localparam int IDX_W = $clog2(NSLV);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_hreadyout, w_hreadyout_next;
    logic              r_hresp, w_hresp_next;
    logic [DATA_W-1:0] r_hrdata, w_hrdata_next;
    logic [ADDR_W-1:0] r_paddr, w_paddr_next;
    logic [NSLV-1:0]   r_psel, w_psel_next;
    logic              r_penable, w_penable_next;
    logic              r_pwrite, w_pwrite_next;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic              w_accept;
    logic              w_illegal;
    logic              w_tmo_hit;
    logic              w_unused_ok;

    assign w_unused_ok = bus.htrans[0];

    // Only IDLE and ERR2 drive hreadyout high, so only they may see a new address phase.
    assign w_accept  = bus.hsel & bus.hready & bus.htrans[1] &
                       ((r_state == S_IDLE) | (r_state == S_ERR2));
    assign w_illegal = (bus.hsize > 3'd2) |
                       ((bus.hsize == 3'd1) & bus.haddr[0]) |
                       ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00));

`ifdef AHB2APB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !bus.pready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // This stalled cycle is the one that brings the count up to TIMEOUT.
    assign w_tmo_hit = !bus.pready && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_hrdata_next = r_hrdata;
        w_paddr_next  = r_paddr;
        w_pwrite_next = r_pwrite;
        w_pwdata_next = r_pwdata;
        w_idx_next    = r_idx;
        case (r_state)
            S_IDLE, S_ERR2: begin
                w_state_next = S_IDLE;
                if (w_accept) begin
                    w_paddr_next  = bus.haddr;
                    w_pwrite_next = bus.hwrite;
                    w_idx_next    = bus.haddr[SLV_SEL_LSB +: IDX_W];
                    if (w_illegal)       w_state_next = S_ERR1;
                    else if (bus.hwrite) w_state_next = S_WDATA;
                    else                 w_state_next = S_SETUP;
                end
            end
            S_WDATA: begin
                w_pwdata_next = bus.hwdata;
                w_state_next  = S_SETUP;
            end
            S_SETUP: w_state_next = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        w_state_next = S_ERR1;
                    end else begin
                        w_state_next = S_IDLE;
                        if (!r_pwrite) w_hrdata_next = bus.prdata;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERR1;
                end
            end
            S_ERR1:  w_state_next = S_ERR2;
            default: w_state_next = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        w_hreadyout_next = (w_state_next == S_IDLE) || (w_state_next == S_ERR2);
        w_hresp_next     = (w_state_next == S_ERR1) || (w_state_next == S_ERR2);
        w_penable_next   = (w_state_next == S_ACCESS);
        w_psel_next      = '0;
        if ((w_state_next == S_SETUP) || (w_state_next == S_ACCESS))
            w_psel_next = NSLV'(1) << w_idx_next;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_paddr     <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_hreadyout <= w_hreadyout_next;
            r_hresp     <= w_hresp_next;
            r_hrdata    <= w_hrdata_next;
            r_paddr     <= w_paddr_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_pwrite    <= w_pwrite_next;
            r_pwdata    <= w_pwdata_next;
            r_idx       <= w_idx_next;
        end
    end

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = r_hrdata;
    assign bus.paddr     = r_paddr;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
endmodule

// File: tb/tb_ahb2apb_periph_bridge.sv
// Scoreboard bench for the AHB-to-APB bridge: expectations queued at accept, checked at completion.
module tb_ahb2apb_periph_bridge;
    localparam int TMO = 4;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb2apb_periph_bridge_if #(.ADDR_W(32), .DATA_W(32), .NSLV(4)) bus ();

    ahb2apb_periph_bridge #(
        .ADDR_W(32), .DATA_W(32), .NSLV(4), .SLV_SEL_LSB(12), .TIMEOUT(TMO)
    ) u_dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    typedef struct {
        int          waits;
        logic        resp;
        logic [31:0] hrdata;
        logic [3:0]  psel;
        int          psel_cyc;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hrdata = 32'h0;

    // APB peripheral model: pready after cur_delay stalled ACCESS cycles.
    int          cur_delay = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_rdata = 32'h0;
    int          acc_cnt = 0;

    assign bus.hready  = bus.hreadyout;
    assign bus.pready  = bus.penable && (acc_cnt == cur_delay);
    assign bus.pslverr = bus.pready && cur_err;
    assign bus.prdata  = bus.pready ? cur_rdata : ~cur_rdata;

    always @(posedge hclk) begin
        if (bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                         input logic [1:0] tr, input logic [31:0] wd, input int dly,
                         input logic err, input logic [31:0] rd, input int gap, input logic tmo);
        exp_t e;
        logic ill;
        int   k;
        ill = (sz > 3'd2) || (sz == 3'd1 && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00);
        e.addr  = addr;
        e.write = wr;
        e.wdata = wd;
        e.gap   = gap;
        if (ill) begin
            e.waits = 1; e.resp = 1'b1; e.psel = 4'b0; e.psel_cyc = 0;
        end else if (tmo) begin
            e.psel = 4'b0001 << addr[13:12];
            e.psel_cyc = 1 + TMO;
            e.waits = (wr ? 2 : 1) + TMO + 1;
            e.resp = 1'b1;
        end else begin
            e.psel = 4'b0001 << addr[13:12];
            e.psel_cyc = 2 + dly;
            e.waits = (wr ? 3 : 2) + dly + (err ? 1 : 0);
            e.resp = err;
            if (!wr && !err) exp_hrdata = rd;
        end
        e.hrdata = exp_hrdata;

        bus.hsel = 1'b1; bus.htrans = tr; bus.haddr = addr; bus.hwrite = wr; bus.hsize = sz;
        k = 0;
        @(negedge hclk);
        while (!bus.hreadyout && k < 100) begin
            @(negedge hclk);
            k++;
        end
        if (!bus.hreadyout) chk("accept_timeout", bus.hreadyout, 1);
        @(posedge hclk);
        sb_q.push_back(e);
        #1;
        cur_delay = dly; cur_err = err; cur_rdata = rd;
        bus.hwdata = wd;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'hFFFF_FFFF;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge hclk);
            k++;
        end
        if (sb_q.size() != 0) begin
            chk("drain", sb_q.size(), 0);
            sb_q.delete();
        end
        @(posedge hclk);
        #1;
    endtask

    // Monitor: accumulates per-transfer observations, compares at the first hreadyout=1 cycle.
    initial begin
        int          waits, pcyc, ecyc, fgap, low_run;
        logic [3:0]  fpsel;
        logic [31:0] fpaddr, fpwdata;
        logic        fpwrite, lo_resp;
        exp_t        e;
        low_run = 0;
        waits = 0; pcyc = 0; ecyc = 0; fgap = -1; fpsel = 0;
        fpaddr = 0; fpwdata = 0; fpwrite = 0; lo_resp = 0;
        forever begin
            @(negedge hclk);
            if (sb_q.size() == 0 || hreset) begin
                waits = 0; pcyc = 0; ecyc = 0; fgap = -1; fpsel = 0; lo_resp = 0;
            end else if (!bus.hreadyout) begin
                waits++;
                lo_resp = bus.hresp;
                if (bus.psel != 4'b0) begin
                    if (pcyc == 0) begin
                        fpsel = bus.psel; fpaddr = bus.paddr;
                        fpwdata = bus.pwdata; fpwrite = bus.pwrite; fgap = low_run;
                    end
                    pcyc++;
                end
                if (bus.penable) ecyc++;
            end else begin
                e = sb_q.pop_front();
                $display("txn addr=%h wr=%0d waits=%0d hresp=%0d hrdata=%h psel=%b",
                         e.addr, e.write, waits, bus.hresp, bus.hrdata, fpsel);
                chk("waits", waits, e.waits);
                chk("hresp", bus.hresp, e.resp);
                chk("hrdata", bus.hrdata, e.hrdata);
                chk("psel", fpsel, e.psel);
                chk("psel_cycles", pcyc, e.psel_cyc);
                chk("penable_cycles", ecyc, (e.psel_cyc > 0) ? e.psel_cyc - 1 : 0);
                chk("psel_done", bus.psel, 0);
                chk("penable_done", bus.penable, 0);
                if (e.resp) chk("err1_hresp", lo_resp, 1);
                if (e.psel_cyc > 0) begin
                    chk("paddr", fpaddr, e.addr);
                    chk("pwrite", fpwrite, e.write);
                    if (e.write) chk("pwdata", fpwdata, e.wdata);
                end
                if (e.gap >= 0) chk("psel_gap", fgap, e.gap);
                waits = 0; pcyc = 0; ecyc = 0; fgap = -1; fpsel = 0; lo_resp = 0;
            end
            low_run = (bus.psel == 4'b0) ? low_run + 1 : 0;
        end
    end

    initial begin
        int k;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'h0;
        bus.hwrite = 1'b0; bus.hsize = 3'd0; bus.hwdata = 32'h0;

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_hreadyout", bus.hreadyout, 1);
        chk("rst_hresp", bus.hresp, 0);
        chk("rst_hrdata", bus.hrdata, 0);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        @(posedge hclk);
        #1 hreset = 1'b0;

        // BUSY with hsel, then NONSEQ without hsel: neither may start anything.
        for (int i = 0; i < 5; i++) begin
            bus.hsel   = (i < 3);
            bus.htrans = (i < 3) ? 2'b01 : 2'b10;
            bus.haddr  = 32'h0000_1000;
            @(negedge hclk);
            chk("noop_hreadyout", bus.hreadyout, 1);
            chk("noop_psel", bus.psel, 0);
            chk("noop_hresp", bus.hresp, 0);
            @(posedge hclk);
            #1;
        end
        bus.hsel = 1'b0; bus.htrans = 2'b00;

        issue(32'h0000_1004, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, -1, 1'b0); drain();
        issue(32'h0000_3010, 1'b1, 3'd2, 2'b10, 32'h1234_5678, 3, 1'b0, 32'h0, -1, 1'b0); drain();
        issue(32'h0000_2000, 1'b0, 3'd2, 2'b10, 32'h0, 1, 1'b1, 32'hCAFE_F00D, -1, 1'b0); drain();
        issue(32'h0000_0002, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h0, -1, 1'b0); drain();
        issue(32'h0000_1001, 1'b1, 3'd1, 2'b10, 32'h0BAD_0BAD, 0, 1'b0, 32'h0, -1, 1'b0); drain();
        issue(32'h0000_0000, 1'b0, 3'd3, 2'b10, 32'h0, 0, 1'b0, 32'h0, -1, 1'b0); drain();
        issue(32'h0000_1002, 1'b0, 3'd1, 2'b10, 32'h0, 2, 1'b0, 32'h0000_BEEF, -1, 1'b0); drain();

        // Back-to-back: psel low for the completion cycle only, plus WDATA ahead of a write.
        issue(32'h0000_0008, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h1111_1111, -1, 1'b0);
        issue(32'h0000_1008, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h2222_2222, 1, 1'b0);
        issue(32'h0000_2008, 1'b1, 3'd2, 2'b11, 32'hA5A5_5A5A, 1, 1'b0, 32'h0, 2, 1'b0);
        drain();

        // New transfer accepted in the ERR2 cycle of an illegal one.
        issue(32'h0000_3001, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h0, -1, 1'b0);
        issue(32'h0000_300C, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h3333_3333, -1, 1'b0);
        drain();

        // Asynchronous reset in the middle of ACCESS.
        issue(32'h0000_2000, 1'b0, 3'd2, 2'b10, 32'h0, 200, 1'b0, 32'h4444_4444, -1, 1'b0);
        k = 0;
        while (!bus.penable && k < 20) begin
            @(negedge hclk);
            k++;
        end
        chk("reached_access", bus.penable, 1);
        #2 hreset = 1'b1;
        #1;
        chk("arst_psel", bus.psel, 0);
        chk("arst_penable", bus.penable, 0);
        chk("arst_hreadyout", bus.hreadyout, 1);
        chk("arst_hresp", bus.hresp, 0);
        chk("arst_hrdata", bus.hrdata, 0);
        sb_q.delete();
        exp_hrdata = 32'h0;
        @(posedge hclk);
        #1 hreset = 1'b0;

        issue(32'h0000_1000, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h55AA_55AA, -1, 1'b0); drain();

`ifdef AHB2APB_TIMEOUT_EN
        issue(32'h0000_1000, 1'b0, 3'd2, 2'b10, 32'h0, 255, 1'b0, 32'h6666_6666, -1, 1'b1); drain();
`endif

        repeat (2) @(posedge hclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
